// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered
// display register that only swaps contents at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned BLANK    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  an_en,
    output logic [6:0]  seg,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned MAXC = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_flag_q, pend_flag_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nibble_d;
    logic          accept;
    logic          copy;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        digit_d    = digit_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                digit_d = '0;
                if (enable) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d    = S_BLANK;
                    cnt_d      = '0;
                    digit_d    = digit_q + 2'd1;
                    frame_done = (digit_q == 2'd3);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                digit_d = '0;
            end
        endcase
    end

    // Pending data reaches the display only when idle or on a frame boundary.
    assign accept = load_valid & ~pend_flag_q;
    assign copy   = pend_flag_q & ((state_q == S_IDLE) | frame_done);

    always_comb begin
        pend_flag_d = pend_flag_q;
        pending_d   = pending_q;
        active_d    = active_q;
        if (copy) begin
            pend_flag_d = 1'b0;
            active_d    = pending_q;
        end else if (accept) begin
            pend_flag_d = 1'b1;
            pending_d   = load_data;
        end
    end

    // Drive outputs from flops computed on next state so the pins never glitch.
    always_comb begin
        case (digit_d)
            2'd0:    nibble_d = active_d[3:0];
            2'd1:    nibble_d = active_d[7:4];
            2'd2:    nibble_d = active_d[11:8];
            default: nibble_d = active_d[15:12];
        endcase
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (state_d == S_ON) begin
            an_d  = ~(4'b0001 << digit_d);
            seg_d = hex_decode(nibble_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            digit_q     <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign load_ready = ~pend_flag_q;
    assign an_en      = an_q;
    assign seg        = seg_q;
    assign digit_sel  = digit_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus pushes per-cycle expected
// pin values, a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] ds;
        logic       fd;
        logic       lr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  an_en;
    logic [6:0]  seg;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;
    int last_fd = -1;
    logic fd_win = 1'b0;

    exp_t  sb[$];
    string tag_q[$];
    logic [6:0] hextab [16];

    display_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .an_en(an_en), .seg(seg), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        hextab[0]  = 7'b1000000; hextab[1]  = 7'b1111001;
        hextab[2]  = 7'b0100100; hextab[3]  = 7'b0110000;
        hextab[4]  = 7'b0011001; hextab[5]  = 7'b0010010;
        hextab[6]  = 7'b0000010; hextab[7]  = 7'b1111000;
        hextab[8]  = 7'b0000000; hextab[9]  = 7'b0010000;
        hextab[10] = 7'b0001000; hextab[11] = 7'b0000011;
        hextab[12] = 7'b1000110; hextab[13] = 7'b0100001;
        hextab[14] = 7'b0000110; hextab[15] = 7'b0001110;
    end

    // p counts cycles since the first blank cycle of a scan; 5 cycles per digit.
    function automatic exp_t exp_scan(input int p, input logic [15:0] act, input logic lr);
        exp_t e;
        int d = (p / 5) % 4;
        int ph = p % 5;
        logic [3:0] one = 4'b0001;
        logic [3:0] nib = act[d*4 +: 4];
        e.an  = (ph == 0) ? 4'b1111 : ~(one << d);
        e.seg = (ph == 0) ? 7'b1111111 : hextab[nib];
        e.ds  = 2'(d);
        e.fd  = (ph == 4) && (d == 3);
        e.lr  = lr;
        return e;
    endfunction

    function automatic exp_t exp_idle(input logic lr);
        exp_t e;
        e.an = 4'b1111; e.seg = 7'b1111111; e.ds = 2'd0; e.fd = 1'b0; e.lr = lr;
        return e;
    endfunction

    task automatic tick(input logic en, input logic lv, input logic [15:0] ld,
                        input exp_t e, input string tag);
        @(posedge clk);
        #1;
        enable     = en;
        load_valid = lv;
        load_data  = ld;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        if ({an_en, seg, digit_sel, frame_done, load_ready} !== {4'b1111, 7'b1111111, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b ds=%0d fd=%b lr=%b, want an=1111 seg=1111111 ds=0 fd=0 lr=1",
                     tag, an_en, seg, digit_sel, frame_done, load_ready);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        string t;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({an_en, seg, digit_sel, frame_done, load_ready} !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got an=%b seg=%b ds=%0d fd=%b lr=%b, want an=%b seg=%b ds=%0d fd=%b lr=%b",
                         t, cyc, an_en, seg, digit_sel, frame_done, load_ready,
                         e.an, e.seg, e.ds, e.fd, e.lr);
            end else begin
                $display("cyc %0d %s an=%b seg=%b ds=%0d fd=%b lr=%b", cyc, t,
                         an_en, seg, digit_sel, frame_done, load_ready);
            end
        end
        checks++;
        if ($countones(~an_en) > 1) begin
            errors++;
            $display("FAIL anode_onehot cyc %0d: got an=%b, want at most one low bit", cyc, an_en);
        end
        if (fd_win && frame_done === 1'b1) begin
            fd_count++;
            if (last_fd >= 0) begin
                checks++;
                if (cyc - last_fd != 20) begin
                    errors++;
                    $display("FAIL fd_spacing cyc %0d: got %0d cycles, want 20", cyc, cyc - last_fd);
                end
            end
            last_fd = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] act;
        logic        lr;
        logic        lv;
        logic [15:0] ld;
        enable = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 chk_reset("reset_async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Blank-data scan, two frames, then disable during digit 2 ON.
        tick(1'b1, 1'b0, 16'h0, exp_idle(1'b1), "idle_to_scan");
        for (int p = 0; p <= 52; p++)
            tick(p < 52, 1'b0, 16'h0, exp_scan(p, 16'h0000, 1'b1), "scan_zero");
        tick(1'b0, 1'b0, 16'h0, exp_idle(1'b1), "disabled_idle");
        tick(1'b1, 1'b0, 16'h0, exp_idle(1'b1), "reenable_idle");
        for (int p = 0; p <= 9; p++)
            tick(1'b1, 1'b0, 16'h0, exp_scan(p, 16'h0000, 1'b1), "rescan");
        tick(1'b0, 1'b0, 16'h0, exp_scan(10, 16'h0000, 1'b1), "drop_in_blank");

        // Load in IDLE: one cycle of load_ready low, then copy to active.
        tick(1'b0, 1'b1, 16'h1234, exp_idle(1'b1), "idle_load_offer");
        tick(1'b0, 1'b0, 16'h0, exp_idle(1'b0), "idle_load_pending");
        tick(1'b1, 1'b0, 16'h0, exp_idle(1'b1), "idle_load_copied");

        // Mid-frame load, ignored second load, 10-frame run, pending load before reset.
        for (int p = 0; p <= 263; p++) begin
            act = (p >= 40) ? 16'hABCD : 16'h1234;
            lr  = ((p >= 28 && p <= 39) || p >= 262) ? 1'b0 : 1'b1;
            lv  = (p == 27 || p == 28 || p == 261);
            ld  = (p == 27) ? 16'hABCD : (p == 28) ? 16'h5555 : 16'h1111;
            tick(1'b1, lv, ld, exp_scan(p, act, lr), (p < 40) ? "scan_1234" : "scan_abcd");
            fd_win = (p >= 60 && p <= 259);
        end

        // Reset pulse mid-ON with a pending load.
        @(negedge clk);
        #1;
        reset = 1'b0; enable = 1'b0; load_valid = 1'b0;
        #1 chk_reset("reset_mid_on");
        #2 reset = 1'b1;
        tick(1'b0, 1'b0, 16'h0, exp_idle(1'b1), "post_reset_idle");
        tick(1'b0, 1'b0, 16'h0, exp_idle(1'b1), "post_reset_no_copy");
        tick(1'b1, 1'b0, 16'h0, exp_idle(1'b1), "post_reset_enable");
        for (int p = 0; p <= 19; p++)
            tick(1'b1, 1'b0, 16'h0, exp_scan(p, 16'h0000, 1'b1), "post_reset_scan");

        @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        checks++;
        if (fd_count != 10) begin
            errors++;
            $display("FAIL frame_done_count: got %0d pulses, want 10", fd_count);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles each digit is driven (ON time); legal range 1..65535.
REQ-002 Parameter BLANK, default 1: clk cycles all anodes are off between digits; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = scan display, 0 = display off.
REQ-006 load_valid  input  1  load_data offered this cycle.
REQ-007 load_data  input  16  four hex digits; [3:0] = digit 0 … [15:12] = digit 3.
REQ-008 load_ready  output  1  1 = controller accepts load_data this cycle.
REQ-009 an_en  output  4  active-low anode enables; bit i drives digit i.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 digit_sel  output  2  index of digit currently selected.
REQ-012 frame_done  output  1  one-cycle pulse at end of each full 4-digit frame.

Function
REQ-013 The FSM SHALL have three states: IDLE, BLANK, ON.
REQ-014 IDLE SHALL drive an_en=4'b1111 and seg=7'b1111111, and SHALL hold digit_sel=0; if enable=1 it SHALL go to BLANK next cycle.
REQ-015 BLANK SHALL last exactly BLANK cycles with an_en=4'b1111 and SHALL then go to ON.
REQ-016 ON SHALL last exactly PRESCALE cycles with an_en = ~(4'b0001 << digit_sel) and seg = decode(active[digit_sel]).
REQ-017 On the last ON cycle, digit_sel SHALL increment modulo 4 on the next edge and the FSM SHALL go to BLANK.
REQ-018 Wrap 3->0 SHALL assert frame_done for exactly that transition cycle (the last ON cycle of digit 3).
REQ-019 enable=0 in BLANK or ON SHALL force IDLE on the next edge; digit_sel=0 and the cycle counter cleared; no frame_done pulse.
REQ-020 Handshake: a transfer occurs when load_valid=1 and load_ready=1 on the same edge; data goes to the 16-bit pending register and the pending flag sets.
REQ-021 load_ready SHALL equal NOT pending flag; load_data is ignored when load_ready=0.
REQ-022 In BLANK/ON, pending SHALL copy to the 16-bit active register only on the frame_done edge; the pending flag clears on that edge (no mid-frame tearing).
REQ-023 In IDLE, a set pending flag SHALL copy to active on the next edge, and the flag SHALL clear.
REQ-024 When pending copies on an edge, no new load is accepted on that edge because load_ready=0; load_ready returns to 1 the following cycle.
REQ-025 Decode SHALL be standard hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 an_en, seg and digit_sel SHALL be glitch-free functions of registered state only, with no combinational path from inputs.
REQ-027 The cycle counter SHALL be wide enough for max(PRESCALE, BLANK)-1 and SHALL restart at 0 on every state entry.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, an_en=4'b1111, seg=7'b1111111, digit_sel=0, frame_done=0, load_ready=1, pending flag=0, active=16'h0000, pending=16'h0000, counter=0.
REQ-029 Reset asserted mid-frame SHALL discard the pending load; after release, operation restarts at REQ-014.

Verification
REQ-030 Reset, enable=1, no load, PRESCALE=4, BLANK=1 -> an_en sequence per 20-cycle frame: 1111 x1, 1110 x4, 1111 x1, 1101 x4, 1111 x1, 1011 x4, 1111 x1, 0111 x4; seg=1000000 whenever an anode is on.
REQ-031 In IDLE, load 16'h1234 -> load_ready=0 for one cycle; active=1234; after enable, digit0 seg=0011001 (4), digit3 seg=1111001 (1).
REQ-032 Mid-frame load 16'hABCD -> old digits are shown until frame_done; frame_done pulses once; the next frame shows D,C,b,A; a second load_valid while pending=1 is ignored.
REQ-033 enable dropped during digit 2 ON -> next cycle an_en=1111, digit_sel=0; re-enable -> scan restarts at digit 0 after 1 blank cycle.
REQ-034 reset pulsed low for 3 ns mid-ON with a pending load -> outputs go to reset values asynchronously; pending data is lost; active=0000.
REQ-035 Run 10 frames -> exactly 10 frame_done pulses, spaced 4*(PRESCALE+BLANK)=20 cycles apart; an_en never has more than one bit low.
